// File: rtl/gcd_job_arbiter.sv
// gcd_job_arbiter: shares one iterative GCD engine among N requesters.
// Round-robin grant, operands latched on grant, engine sequenced through
// ISSUE/WAIT, result returned with the winning requester's index.
// Optional feature macro: GCD_ZERO_BYPASS_EN (zero-operand jobs skip the engine).
module gcd_job_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 7,
  parameter int unsigned CW = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N-1:0]         req_valid_i,
  input  logic [N*W-1:0]       req_a_i,
  input  logic [N*W-1:0]       req_b_i,
  output logic [N-1:0]         req_ready_o,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [W-1:0]         resp_data_o,
  output logic [$clog2(N)-1:0] resp_id_o,
  output logic                 eng_start_o,
  output logic [W-1:0]         eng_a_o,
  output logic [W-1:0]         eng_b_o,
  input  logic                 eng_done_i,
  input  logic [W-1:0]         eng_result_i,
  output logic                 busy_o,
  output logic [CW-1:0]        jobs_done_o
);

  localparam int unsigned IdW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q;
  logic [IdW-1:0]  ptr_q;
  logic [IdW-1:0]  id_q;
  logic [W-1:0]    eng_a_q;
  logic [W-1:0]    eng_b_q;
  logic [W-1:0]    resp_data_q;
  logic [CW-1:0]   jobs_q;

  logic            gnt_valid;
  logic [IdW-1:0]  gnt_idx;
  logic [IdW-1:0]  cand;
  logic [W-1:0]    gnt_a;
  logic [W-1:0]    gnt_b;

  // Round-robin search starting just above the last winner, wrapping modulo N.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IdW'((32'(ptr_q) + k) % N);
      if (!gnt_valid && req_valid_i[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
    gnt_a = req_a_i[gnt_idx*W +: W];
    gnt_b = req_b_i[gnt_idx*W +: W];
  end

  // Accept pulse is only offered in IDLE, and is forced low while reset is asserted.
  always_comb begin
    req_ready_o = '0;
    if (rst_ni && (state_q == StIdle) && gnt_valid) begin
      req_ready_o[gnt_idx] = 1'b1;
    end
  end

  // Job sequencing FSM with latched operands, result, owner id and job counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      ptr_q       <= IdW'(N - 1);
      id_q        <= '0;
      eng_a_q     <= '0;
      eng_b_q     <= '0;
      resp_data_q <= '0;
      jobs_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt_valid) begin
            eng_a_q <= gnt_a;
            eng_b_q <= gnt_b;
            id_q    <= gnt_idx;
            ptr_q   <= gnt_idx;
`ifdef GCD_ZERO_BYPASS_EN
            if ((gnt_a == '0) || (gnt_b == '0)) begin
              // gcd(x, 0) = x, so the nonzero operand is the answer.
              resp_data_q <= gnt_a | gnt_b;
              state_q     <= StResp;
            end else begin
              state_q <= StIssue;
            end
`else
            state_q <= StIssue;
`endif
          end
        end
        StIssue: begin
          state_q <= StWait;
        end
        StWait: begin
          if (eng_done_i) begin
            resp_data_q <= eng_result_i;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (resp_ready_i) begin
            jobs_q  <= jobs_q + 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign eng_start_o  = (state_q == StIssue);
  assign resp_valid_o = (state_q == StResp);
  assign busy_o       = (state_q != StIdle);
  assign eng_a_o      = eng_a_q;
  assign eng_b_o      = eng_b_q;
  assign resp_data_o  = resp_data_q;
  assign resp_id_o    = id_q;
  assign jobs_done_o  = jobs_q;

endmodule

// File: tb/tb_gcd_job_arbiter.sv
// Scoreboard bench for gcd_job_arbiter with a behavioural multi-cycle GCD engine.
module tb_gcd_job_arbiter;

  localparam int N  = 4;
  localparam int W  = 7;
  localparam int CW = 8;

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] data;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   req_ready;
  logic           resp_valid;
  logic           resp_ready = 1'b1;
  logic [W-1:0]   resp_data;
  logic [1:0]     resp_id;
  logic           eng_start;
  logic [W-1:0]   eng_a;
  logic [W-1:0]   eng_b;
  logic           eng_done;
  logic [W-1:0]   eng_result;
  logic           busy;
  logic [CW-1:0]  jobs_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int starts = 0;
  int resp_cnt = 0;
  int last_grant_cyc = 0;
  int last_done_cyc = 0;
  int last_hs_cyc = 0;
  int hs_in_contend = 0;
  bit contend = 1'b0;
  bit prev_rv = 1'b0;
  logic [CW-1:0] exp_jobs = '0;
  int eng_lat = 2;
  exp_t sb[$];
  int grant_log[$];

  gcd_job_arbiter #(.N(N), .W(W), .CW(CW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_ready_o  (req_ready),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data),
    .resp_id_o    (resp_id),
    .eng_start_o  (eng_start),
    .eng_a_o      (eng_a),
    .eng_b_o      (eng_b),
    .eng_done_i   (eng_done),
    .eng_result_i (eng_result),
    .busy_o       (busy),
    .jobs_done_o  (jobs_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] gcd7(input logic [W-1:0] a_in, input logic [W-1:0] b_in);
    logic [W-1:0] a, b, t;
    a = a_in;
    b = b_in;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Behavioural engine: latches operands on start, pulses done eng_lat+1 cycles later.
  logic [W-1:0] ea, eb;
  int ecnt;
  bit ebusy;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ebusy      <= 1'b0;
      eng_done   <= 1'b0;
      eng_result <= '0;
      ecnt       <= 0;
      ea         <= '0;
      eb         <= '0;
    end else begin
      eng_done <= 1'b0;
      if (eng_start) begin
        ea    <= eng_a;
        eb    <= eng_b;
        ecnt  <= eng_lat;
        ebusy <= 1'b1;
      end else if (ebusy) begin
        if (ecnt == 0) begin
          eng_done   <= 1'b1;
          eng_result <= gcd7(ea, eb);
          ebusy      <= 1'b0;
        end else begin
          ecnt <= ecnt - 1;
        end
      end
    end
  end

  // Monitor: grant legality, latency, job counter and scoreboard compare.
  always @(negedge clk) begin
    int g;
    int exp_cyc;
    exp_t e;
    if (!rst_n) begin
      exp_jobs = '0;
      prev_rv  = 1'b0;
    end else begin
      checks++;
      if (jobs_done !== exp_jobs) begin
        errors++;
        $display("FAIL jobs_done got %0d want %0d", jobs_done, exp_jobs);
      end
      if (req_ready != '0) begin
        checks++;
        if (!$onehot(req_ready) || ((req_ready & ~req_valid) != '0)) begin
          errors++;
          $display("FAIL req_ready_onehot got %b with req_valid %b", req_ready, req_valid);
        end
        g = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        grant_log.push_back(g);
        last_grant_cyc = cyc;
        if (contend && hs_in_contend > 0) begin
          checks++;
          if (cyc != last_hs_cyc + 1) begin
            errors++;
            $display("FAIL regrant_latency got cycle %0d want %0d", cyc, last_hs_cyc + 1);
          end
        end
      end
      if (eng_start) begin
        starts++;
        checks++;
        if (cyc != last_grant_cyc + 1) begin
          errors++;
          $display("FAIL eng_start_latency got cycle %0d want %0d", cyc, last_grant_cyc + 1);
        end
      end
      if (eng_done) last_done_cyc = cyc;
      if (resp_valid && !prev_rv) begin
        exp_cyc = (last_done_cyc > last_grant_cyc) ? last_done_cyc + 1 : last_grant_cyc + 1;
        checks++;
        if (cyc != exp_cyc) begin
          errors++;
          $display("FAIL resp_valid_latency got cycle %0d want %0d", cyc, exp_cyc);
        end
      end
      prev_rv = resp_valid;
      if (resp_valid && resp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected got id %0d data %0d want none", resp_id, resp_data);
        end else begin
          e = sb.pop_front();
          if (resp_id !== e.id || resp_data !== e.data) begin
            errors++;
            $display("FAIL resp got id %0d data %0d want id %0d data %0d",
                     resp_id, resp_data, e.id, e.data);
          end
        end
        resp_cnt++;
        exp_jobs = exp_jobs + 1'b1;
        last_hs_cyc = cyc;
        if (contend) hs_in_contend++;
      end
    end
  end

  task automatic check_zero(input string name);
    checks++;
    if ({req_ready, resp_valid, resp_data, resp_id, eng_start, eng_a, eng_b, busy, jobs_done}
        !== '0) begin
      errors++;
      $display("FAIL %s got rdy %b rv %b data %0d id %0d st %b a %0d b %0d busy %b jobs %0d want 0",
               name, req_ready, resp_valid, resp_data, resp_id, eng_start, eng_a, eng_b,
               busy, jobs_done);
    end
  endtask

  task automatic wait_grant(input int n0);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (grant_log.size() > n0) break;
    end
    #1;
    if (grant_log.size() <= n0) begin
      errors++;
      $display("FAIL grant_timeout got %0d grants want more than %0d", grant_log.size(), n0);
    end
  endtask

  task automatic wait_resp(input int n);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (resp_cnt >= n) break;
    end
    #1;
    if (resp_cnt < n) begin
      errors++;
      $display("FAIL resp_timeout got %0d responses want %0d", resp_cnt, n);
    end
  endtask

  task automatic push_exp(input int r, input logic [W-1:0] d);
    exp_t e;
    e.id   = 2'(r);
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic run_job(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_d);
    int n0, nr;
    n0 = grant_log.size();
    nr = resp_cnt;
    push_exp(r, exp_d);
    @(posedge clk);
    #1;
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
    req_valid[r]    = 1'b1;
    wait_grant(n0);
    req_valid[r] = 1'b0;
    checks++;
    if (grant_log.size() > n0 && grant_log[$] != r) begin
      errors++;
      $display("FAIL grant_id got %0d want %0d", grant_log[$], r);
    end
    wait_resp(nr + 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("reset_outputs");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n0, nr, s0;
    int order[5] = '{0, 1, 2, 3, 0};
    bit seen;

    // Reset state, with a pending request that must not be acknowledged.
    req_valid = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    check_zero("initial_reset");
    req_valid = '0;
    rst_n = 1'b1;

    // Contention: all four requesting, grant order 0,1,2,3,0.
    do_reset();
    eng_lat = 2;
    req_a = {7'd7, 7'd12, 7'd60, 7'd27};
    req_b = {7'd5, 7'd18, 7'd40, 7'd15};
    push_exp(0, 7'd3);
    push_exp(1, 7'd20);
    push_exp(2, 7'd6);
    push_exp(3, 7'd1);
    push_exp(0, 7'd3);
    n0 = grant_log.size();
    nr = resp_cnt;
    contend = 1'b1;
    hs_in_contend = 0;
    @(posedge clk);
    #1;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) wait_grant(n0 + k);
    req_valid = '0;
    wait_resp(nr + 5);
    contend = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (grant_log.size() <= n0 + k || grant_log[n0 + k] != order[k]) begin
        errors++;
        $display("FAIL rr_order slot %0d got %0d want %0d", k,
                 (grant_log.size() > n0 + k) ? grant_log[n0 + k] : -1, order[k]);
      end
    end

    // Single job: exactly one eng_start, gcd(60,40)=20.
    s0 = starts;
    run_job(0, 7'd60, 7'd40, 7'd20);
    checks++;
    if (starts != s0 + 1) begin
      errors++;
      $display("FAIL single_starts got %0d want %0d", starts - s0, 1);
    end
    checks++;
    if (jobs_done !== 8'd6) begin
      errors++;
      $display("FAIL single_jobs got %0d want %0d", jobs_done, 6);
    end

    // Backpressure: response held for 10 cycles while requester 3 waits.
    resp_ready = 1'b0;
    push_exp(1, 7'd6);
    push_exp(3, 7'd1);
    n0 = grant_log.size();
    nr = resp_cnt;
    @(posedge clk);
    #1;
    req_a[1*W +: W] = 7'd12;
    req_b[1*W +: W] = 7'd18;
    req_valid = 4'b0010;
    wait_grant(n0);
    req_a[3*W +: W] = 7'd7;
    req_b[3*W +: W] = 7'd5;
    req_valid = 4'b1000;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_resp_timeout got 0 want 1");
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (!resp_valid || resp_data !== 7'd6 || resp_id !== 2'd1 || !busy ||
          grant_log.size() != n0 + 1) begin
        errors++;
        $display("FAIL backpressure cyc %0d got rv %b data %0d id %0d busy %b grants %0d want 1 6 1 1 %0d",
                 i, resp_valid, resp_data, resp_id, busy, grant_log.size(), n0 + 1);
      end
    end
    resp_ready = 1'b1;
    wait_grant(n0 + 1);
    req_valid = '0;
    wait_resp(nr + 2);

    // Reset while waiting on the engine.
    eng_lat = 20;
    n0 = grant_log.size();
    @(posedge clk);
    #1;
    req_a[0 +: W] = 7'd60;
    req_b[0 +: W] = 7'd40;
    req_valid = 4'b0001;
    wait_grant(n0);
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_wait");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    eng_lat = 1;
    run_job(2, 7'd12, 7'd18, 7'd6);

    // Zero operand.
    s0 = starts;
    run_job(0, 7'd0, 7'd9, 7'd9);
    checks++;
`ifdef GCD_ZERO_BYPASS_EN
    if (starts != s0) begin
      errors++;
      $display("FAIL zero_starts got %0d want %0d", starts - s0, 0);
    end
`else
    if (starts != s0 + 1) begin
      errors++;
      $display("FAIL zero_starts got %0d want %0d", starts - s0, 1);
    end
`endif

    // Counter wrap: 2 jobs done since reset, 254 more reach 256 -> 0.
    eng_lat = 0;
    for (int k = 0; k < 254; k++) run_job(k % N, 7'd60, 7'd40, 7'd20);
    checks++;
    if (jobs_done !== 8'd0) begin
      errors++;
      $display("FAIL jobs_wrap got %0d want %0d", jobs_done, 0);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d want %0d", sb.size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_job_arbiter.md
Name: gcd_job_arbiter

Overview:
Shares one iterative GCD engine (start/done handshake, W-bit operands) among N requesters.
- Round-robin grant; operands are latched on grant.
- Sequences the engine and returns the result with the winning requester's ID.
- Sits between the operand sources (FIFOs, host logic) and the single GCD datapath in top.

Parameters:
N, 4, number of requesters (2..8)
W, 7, operand/result width
CW, 8, width of completed-job counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  N  per-requester job request; held with stable operands until accepted
req_a  in  N*W  operand A, requester i at bits [i*W +: W]
req_b  in  N*W  operand B, same packing
req_ready  out  N  one-cycle accept pulse, one-hot
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_data  out  W  GCD result
resp_id  out  clog2(N)  index of requester that owns resp_data
eng_start  out  1  one-cycle start pulse to GCD engine
eng_a  out  W  latched operand A to engine
eng_b  out  W  latched operand B to engine
eng_done  in  1  engine completion pulse
eng_result  in  W  engine result, valid with eng_done
busy  out  1  high in any state except IDLE
jobs_done  out  CW  count of completed responses

Behaviour:
- Reset (rst=0, async): state=IDLE.
  - All outputs 0: req_ready, resp_valid, resp_data, resp_id, eng_start, eng_a, eng_b, busy, jobs_done.
  - RR pointer = N-1, so requester 0 has highest priority first.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, grant g = first set bit searching from ptr+1 upward, wrapping modulo N.
  - Same cycle: req_ready[g]=1; latch req_a/req_b slice g into eng_a/eng_b; latch id=g; ptr<=g; go ISSUE.
  - If no req_valid, stay in IDLE.
- ISSUE: eng_start=1 for exactly one cycle; go WAIT.
- WAIT:
  - eng_a/eng_b remain stable.
  - On eng_done=1: capture eng_result into resp_data; go RESP.
  - eng_done in IDLE, ISSUE or RESP is ignored.
- RESP:
  - resp_valid=1; resp_data and resp_id stable until resp_valid && resp_ready.
  - On that handshake: jobs_done++ (wraps 2^CW-1 -> 0); go IDLE.
- Latency:
  - Grant at cycle T; eng_start at T+1.
  - eng_done at cycle D gives resp_valid at D+1.
  - With resp_ready tied high, the next grant is possible at D+2. At least one IDLE cycle separates jobs.
- req_valid changes: a requester may drop req_valid before grant with no effect. A new request arriving in a non-IDLE state waits.
- Simultaneous requests: exactly one req_ready per grant; never more than one bit set.
- Fairness: a continuously requesting requester is served within N grants.
- Reset mid-operation returns to IDLE. An in-flight engine job is abandoned; the engine is reset by the same rst.

Optional Feature:
Macro: GCD_ZERO_BYPASS_EN
- Defined: on grant, if latched a==0 or b==0, go directly IDLE->RESP.
  - resp_data = a|b (the nonzero operand; 0 if both are zero).
  - eng_start is never pulsed; resp_valid is asserted at T+1.
- Not defined: zero operands are issued to the engine like any other job. Correctness is then the engine's responsibility.

Test Plan:
- Single job: req_valid=0001, a=60, b=40 -> req_ready=0001 for one cycle, one eng_start, resp_data=20, resp_id=0, jobs_done=1.
- Contention: req_valid=1111 held; jobs (27,15),(60,40),(12,18),(7,5) -> grant order 0,1,2,3,0; results 3,20,6,1.
- Backpressure: resp_ready=0 for 10 cycles after resp_valid -> resp_data/resp_id stable, no new grant, busy=1 throughout.
- Reset mid-WAIT: assert rst=0 while waiting on eng_done -> all outputs 0 immediately; after release, req_valid=0100 is granted to requester 2.
- Zero operand: a=0, b=9 -> with GCD_ZERO_BYPASS_EN, resp_data=9 at T+1 and no eng_start; without it, eng_start pulses and the result comes from the engine.
- Counter wrap: 256 completed jobs with CW=8 -> jobs_done returns to 0.
